// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared definitions for the UART receive frame controller: FSM state
// encoding, parity-type encoding, the minimum oversampling ratio and a
// parity helper.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic PAR_EVEN     = 1'b0;
  localparam logic PAR_ODD      = 1'b1;
  localparam int   MIN_PRESCALE = 8;

  // Parity bit the transmitter should have sent, given the XOR of the data.
  function automatic logic expected_parity(input logic data_xor, input logic par_typ);
    return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Signal bundle between the UART frame controller and its environment:
// serial line, frame configuration, data_sampler handshake and frame results.
// The controller uses the slave view; the driving environment the master view.
interface uart_rx_frame_ctrl_if #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int DATA_WIDTH     = 8
);
  logic                      rx_in;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      par_en;
  logic                      par_typ;
  logic                      sampled_bit;
  logic                      data_sampler_enable;
  logic                      sampling_tick;
  logic [DATA_WIDTH-1:0]     p_data;
  logic                      data_valid;
  logic                      par_err;
  logic                      stp_err;
  logic                      break_det;

  modport slave (
    input  rx_in, prescale, par_en, par_typ, sampled_bit,
    output data_sampler_enable, sampling_tick, p_data, data_valid,
           par_err, stp_err, break_det
  );

  modport master (
    output rx_in, prescale, par_en, par_typ, sampled_bit,
    input  data_sampler_enable, sampling_tick, p_data, data_valid,
           par_err, stp_err, break_det
  );
endinterface

// File: rtl/uart_rx_frame_ctrl_counter.sv
// Per-bit edge counter and frame bit counter for the UART receiver.
// edge_cnt runs 0..prescale-1 while a frame is active; bit_cnt advances on
// each wrap. Decodes the sampler strobe window and the evaluation point
// from the prescale value latched at start detection.
module uart_rx_edge_bit_counter #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_W      = 4
) (
  input  logic                      rx_clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic                      i_active,
  input  logic                      i_clear,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic                      o_wrap,
  output logic                      o_tick,
  output logic                      o_eval,
  output logic [BIT_CNT_W-1:0]      o_bit_cnt
);

  logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
  logic [BIT_CNT_W-1:0]      r_bit_cnt;
  logic [PRESCALE_WIDTH-1:0] w_last;
  logic [PRESCALE_WIDTH-1:0] w_half;

  assign w_last    = i_prescale - PRESCALE_WIDTH'(1);
  assign w_half    = i_prescale >> 1;
  assign o_wrap    = i_active && (r_edge_cnt == w_last);
  assign o_tick    = i_active && ((r_edge_cnt == w_half - PRESCALE_WIDTH'(2)) ||
                                  (r_edge_cnt == w_half - PRESCALE_WIDTH'(1)) ||
                                  (r_edge_cnt == w_half));
  assign o_eval    = i_active && (r_edge_cnt == w_half + PRESCALE_WIDTH'(2));
  assign o_bit_cnt = r_bit_cnt;

  // Edge/bit counting: the start-detect cycle is edge 0, so START begins at edge 1.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    if (!rst_n) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (i_clear) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (i_start) begin
      r_edge_cnt <= PRESCALE_WIDTH'(1);
      r_bit_cnt  <= '0;
    end else if (i_active) begin
      if (o_wrap) begin
        r_edge_cnt <= '0;
        r_bit_cnt  <= r_bit_cnt + BIT_CNT_W'(1);
      end else begin
        r_edge_cnt <= r_edge_cnt + PRESCALE_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller. Detects the start bit, drives the external
// data_sampler, deserialises LSB-first data and checks parity and stop bit.
// Optional feature macro: UART_RX_BREAK_DETECT_EN (break strobe plus an
// idle-high re-arm wait before the next start bit is accepted).
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6,
  parameter int DATA_WIDTH     = 8
) (
  input logic               rx_clk,
  input logic               rst_n,
  uart_rx_frame_ctrl_if.slave bus
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 3);

  rx_state_e                 r_state;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic                      r_par_en;
  logic                      r_par_typ;
  logic [DATA_WIDTH-1:0]     r_shreg;
  logic [DATA_WIDTH-1:0]     r_p_data;
  logic                      r_par_bad;
  logic                      r_stp_bad;
  logic                      r_data_valid;
  logic                      r_par_err;
  logic                      r_stp_err;

  logic                      w_armed;
  logic                      w_active;
  logic                      w_start_det;
  logic                      w_clear;
  logic                      w_wrap;
  logic                      w_tick;
  logic                      w_eval;
  logic [BIT_CNT_W-1:0]      w_bit_cnt;
  logic [PRESCALE_WIDTH-1:0] w_prescale_in;

`ifdef UART_RX_BREAK_DETECT_EN
  logic                      r_break_det;
  logic                      r_rearm_wait;
  logic [PRESCALE_WIDTH-1:0] r_rearm_cnt;

  assign w_armed       = ~r_rearm_wait;
  assign bus.break_det = r_break_det;
`else
  assign w_armed       = 1'b1;
  assign bus.break_det = 1'b0;
`endif

  // Ratios below the minimum are run at the minimum.
  assign w_prescale_in = (bus.prescale < PRESCALE_WIDTH'(MIN_PRESCALE)) ?
                         PRESCALE_WIDTH'(MIN_PRESCALE) : bus.prescale;

  assign w_active    = (r_state != IDLE);
  assign w_start_det = (r_state == IDLE) && w_armed && !bus.rx_in;
  assign w_clear     = ((r_state == START) && w_eval && bus.sampled_bit) ||
                       ((r_state == STOP) && w_wrap);

  assign bus.data_sampler_enable = w_active;
  assign bus.sampling_tick       = w_tick;
  assign bus.p_data              = r_p_data;
  assign bus.data_valid          = r_data_valid;
  assign bus.par_err             = r_par_err;
  assign bus.stp_err             = r_stp_err;

  uart_rx_edge_bit_counter #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH),
    .BIT_CNT_W      (BIT_CNT_W)
  ) u_counter (
    .rx_clk     (rx_clk),
    .rst_n      (rst_n),
    .i_start    (w_start_det),
    .i_active   (w_active),
    .i_clear    (w_clear),
    .i_prescale (r_prescale),
    .o_wrap     (w_wrap),
    .o_tick     (w_tick),
    .o_eval     (w_eval),
    .o_bit_cnt  (w_bit_cnt)
  );

  // Frame FSM with shift register, error flags and registered result strobes.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_prescale   <= PRESCALE_WIDTH'(MIN_PRESCALE);
      r_par_en     <= 1'b0;
      r_par_typ    <= PAR_EVEN;
      r_shreg      <= '0;
      r_p_data     <= '0;
      r_par_bad    <= 1'b0;
      r_stp_bad    <= 1'b0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      r_break_det  <= 1'b0;
      r_rearm_wait <= 1'b0;
      r_rearm_cnt  <= '0;
`endif
    end else begin
      // NOTE: result strobes default low every cycle and are raised only in
      // the frame-end branch, which makes them exactly one cycle wide.
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      r_break_det  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
`ifdef UART_RX_BREAK_DETECT_EN
          // After a break the line must be idle-high for a full bit time.
          if (r_rearm_wait) begin
            if (!bus.rx_in) begin
              r_rearm_cnt <= '0;
            end else if (r_rearm_cnt == r_prescale - PRESCALE_WIDTH'(1)) begin
              r_rearm_wait <= 1'b0;
              r_rearm_cnt  <= '0;
            end else begin
              r_rearm_cnt <= r_rearm_cnt + PRESCALE_WIDTH'(1);
            end
          end
`endif
          if (w_start_det) begin
            r_state    <= START;
            r_prescale <= w_prescale_in;
            r_par_en   <= bus.par_en;
            r_par_typ  <= bus.par_typ;
            r_par_bad  <= 1'b0;
            r_stp_bad  <= 1'b0;
          end
        end
        START: begin
          if (w_eval && bus.sampled_bit) begin
            r_state <= IDLE;
          end else if (w_wrap) begin
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_eval) begin
            r_shreg <= {bus.sampled_bit, r_shreg[DATA_WIDTH-1:1]};
          end
          if (w_wrap && (w_bit_cnt == BIT_CNT_W'(DATA_WIDTH))) begin
            r_state <= r_par_en ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (w_eval) begin
            r_par_bad <= (bus.sampled_bit != expected_parity(^r_shreg, r_par_typ));
          end
          if (w_wrap) begin
            r_state <= STOP;
          end
        end
        STOP: begin
          if (w_eval) begin
            r_stp_bad <= ~bus.sampled_bit;
          end
          if (w_wrap) begin
            r_state <= IDLE;
            if (!r_par_bad && !r_stp_bad) begin
              r_p_data     <= r_shreg;
              r_data_valid <= 1'b1;
            end else begin
              r_par_err <= r_par_bad;
              r_stp_err <= r_stp_bad;
            end
`ifdef UART_RX_BREAK_DETECT_EN
            if (r_stp_bad && (r_shreg == '0)) begin
              r_break_det  <= 1'b1;
              r_rearm_wait <= 1'b1;
              r_rearm_cnt  <= '0;
            end
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: models the 3-tap majority data_sampler,
// drives frames from a vector table plus hand-written corner sequences, and
// compares every result strobe against a scoreboard queue.
module tb_uart_rx_frame_ctrl;
  import uart_rx_pkg::*;

  localparam int PW = 6;
  localparam int DW = 8;

  logic rx_clk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 rx_clk = ~rx_clk;

  uart_rx_frame_ctrl_if #(.PRESCALE_WIDTH(PW), .DATA_WIDTH(DW)) bus ();

  uart_rx_frame_ctrl #(.PRESCALE_WIDTH(PW), .DATA_WIDTH(DW)) dut (
    .rx_clk (rx_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [PW-1:0] ps;
    logic          pe;
    logic          pt;
    logic [DW-1:0] data;
    logic          flip;   // corrupt the parity bit
    logic          stop;
    logic          ev, ep, es, eb;  // expected valid / par_err / stp_err / break
  } vec_t;

  typedef struct {
    logic          valid, perr, serr, brk;
    logic [DW-1:0] pdata;
    int            cyc;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  logic [DW-1:0] last_good = '0;
  vec_t          vecs[9];
  int            t0;

  always @(posedge rx_clk) cyc <= cyc + 1;

  // data_sampler model: 3-deep shift on sampling_tick, majority out.
  logic [2:0] smp;
  always @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) smp <= 3'b111;
    else if (bus.sampling_tick) smp <= {smp[1:0], bus.rx_in};
  end
  assign bus.sampled_bit = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result monitor: every strobe cycle must match the oldest expectation.
  always @(negedge rx_clk) begin
    if (rst_n && (bus.data_valid || bus.par_err || bus.stp_err || bus.break_det)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_strobe",
              {28'd0, bus.data_valid, bus.par_err, bus.stp_err, bus.break_det}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("data_valid", bus.data_valid, mon_e.valid);
        check("par_err",    bus.par_err,    mon_e.perr);
        check("stp_err",    bus.stp_err,    mon_e.serr);
        check("break_det",  bus.break_det,  mon_e.brk);
        check("p_data",     bus.p_data,     mon_e.pdata);
        check("frame_end_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic idle(input int n);
    bus.rx_in = 1'b1;
    repeat (n) @(negedge rx_clk);
  endtask

  // Drive one frame starting at the current negedge; optionally push its result.
  task automatic send_frame(input logic [PW-1:0] ps, input logic pe, input logic pt,
                            input logic [DW-1:0] data, input logic flip, input logic stop,
                            input bit push, input logic ev, input logic ep,
                            input logic es, input logic eb);
    int         eff;
    int         nbits;
    logic       par;
    logic [11:0] fr;
    exp_t       e;
    eff   = (int'(ps) < MIN_PRESCALE) ? MIN_PRESCALE : int'(ps);
    nbits = 10 + int'(pe);
    par   = (pt ? ~(^data) : ^data) ^ flip;
    fr    = '1;
    fr[0] = 1'b0;
    for (int i = 0; i < DW; i++) fr[1+i] = data[i];
    if (pe) begin
      fr[9]  = par;
      fr[10] = stop;
    end else begin
      fr[9] = stop;
    end
    if (push) begin
      e.valid = ev;
      e.perr  = ep;
      e.serr  = es;
`ifdef UART_RX_BREAK_DETECT_EN
      e.brk   = eb;
`else
      e.brk   = 1'b0;
`endif
      if (ev) last_good = data;
      e.pdata = last_good;
      e.cyc   = cyc + nbits * eff;
      sb_q.push_back(e);
    end
    bus.prescale = ps;
    bus.par_en   = pe;
    bus.par_typ  = pt;
    for (int b = 0; b < nbits; b++) begin
      bus.rx_in = fr[b];
      if (b == 0) begin
        @(negedge rx_clk);
        // Configuration changes mid-frame must not matter.
        bus.prescale = (ps == PW'(8)) ? PW'(32) : PW'(8);
        bus.par_en   = ~pe;
        bus.par_typ  = ~pt;
        repeat (eff - 1) @(negedge rx_clk);
      end else begin
        repeat (eff) @(negedge rx_clk);
      end
    end
    bus.rx_in = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge rx_clk);
      n++;
    end
    check("scoreboard_drained", sb_q.size(), 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        ps     pe    pt    data   flip  stop  ev    ep    es    eb
    vecs[0] = '{6'd8,  1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{6'd8,  1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{6'd16, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{6'd16, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{6'd16, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{6'd4,  1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{6'd32, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{6'd8,  1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{6'd16, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    bus.rx_in    = 1'b1;
    bus.prescale = 6'd16;
    bus.par_en   = 1'b0;
    bus.par_typ  = 1'b0;

    // Reset state.
    repeat (3) @(negedge rx_clk);
    check("rst_enable",     bus.data_sampler_enable, 0);
    check("rst_tick",       bus.sampling_tick,       0);
    check("rst_p_data",     bus.p_data,              0);
    check("rst_data_valid", bus.data_valid,          0);
    check("rst_par_err",    bus.par_err,             0);
    check("rst_stp_err",    bus.stp_err,             0);
    check("rst_break_det",  bus.break_det,           0);
    rst_n = 1'b1;
    idle(5);

    // Table-driven frames.
    for (int v = 0; v < 9; v++) begin
      send_frame(vecs[v].ps, vecs[v].pe, vecs[v].pt, vecs[v].data, vecs[v].flip,
                 vecs[v].stop, 1'b1, vecs[v].ev, vecs[v].ep, vecs[v].es, vecs[v].eb);
      drain(4);
      idle(2 * 32 + 4);
    end

    // Start-bit glitch: 3 low cycles at prescale 16 -> back to IDLE after eval.
    bus.prescale = 6'd16;
    bus.par_en   = 1'b0;
    bus.rx_in    = 1'b0;
    t0 = cyc;
    repeat (3) @(negedge rx_clk);
    bus.rx_in = 1'b1;
    while (cyc < t0 + 10) @(negedge rx_clk);
    check("glitch_enable_at_eval", bus.data_sampler_enable, 1);
    @(negedge rx_clk);
    check("glitch_idle_after_eval", bus.data_sampler_enable, 0);
    idle(20);
    send_frame(6'd16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drain(4);
    idle(10);

    // Back-to-back frames at prescale 32, odd parity.
    send_frame(6'd32, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(6'd32, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drain(4);
    idle(10);

`ifdef UART_RX_BREAK_DETECT_EN
    // Break: line held low afterwards must not start a frame until re-armed.
    send_frame(6'd16, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    bus.rx_in = 1'b0;
    repeat (40) @(negedge rx_clk);
    check("break_hold_low_idle", bus.data_sampler_enable, 0);
    drain(4);
    idle(15);
    bus.rx_in = 1'b0;
    @(negedge rx_clk);
    @(negedge rx_clk);
    check("break_rearm_short_idle", bus.data_sampler_enable, 0);
    idle(17);
    send_frame(6'd16, 1'b0, 1'b0, 8'h42, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drain(4);
    idle(10);
`endif

    // Asynchronous reset in the middle of DATA.
    bus.prescale = 6'd16;
    bus.par_en   = 1'b0;
    bus.rx_in    = 1'b0;
    repeat (16 * 3 + 5) @(negedge rx_clk);
    check("mid_data_enable", bus.data_sampler_enable, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_enable",     bus.data_sampler_enable, 0);
    check("mid_rst_tick",       bus.sampling_tick,       0);
    check("mid_rst_p_data",     bus.p_data,              0);
    check("mid_rst_data_valid", bus.data_valid,          0);
    check("mid_rst_par_err",    bus.par_err,             0);
    check("mid_rst_stp_err",    bus.stp_err,             0);
    check("mid_rst_break_det",  bus.break_det,           0);
    @(negedge rx_clk);
    bus.rx_in = 1'b1;
    last_good = '0;
    repeat (3) @(negedge rx_clk);
    rst_n = 1'b1;
    idle(5);
    send_frame(6'd16, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drain(4);
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
